// File: rtl/alu_exec_mc.sv
// -----------------------------------------------------------------------------
// alu_exec_mc
//
// Multi-cycle execute-stage ALU for the RISC-V core. Sits between the ID/EX
// operand registers and the EX/MEM register. Single-cycle operations return a
// registered result one cycle after accept; MUL runs on an iterative
// shift-add engine (one multiplier bit per cycle) and stalls the pipeline
// until the product is ready.
//
// Ports:
//   clk          core clock, rising edge
//   rst_n        asynchronous active-low reset
//   valid_i      operands and op code present this cycle
//   ALUSignal_i  op code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 MUL, 6 XOR,
//                7 SL, 8 SRA, 9 SRL, 10..15 undefined (result 0)
//   src1_i       operand A / MUL multiplicand
//   src2_i       operand B / MUL multiplier / shift amount (low SHW bits)
//   flush_i      abort any op in flight; blocks accept this cycle
//   ready_o      block can accept a new op this cycle
//   stall_o      hold upstream pipeline registers
//   valid_o      result_o / zero_o valid, one-cycle pulse
//   result_o     registered result, held between valid pulses
//   zero_o       registered (result == 0), held between valid pulses
//   dbg_state_o  current FSM state (IDLE=0, MUL=1, DONE=2)
//
// Handshake: an op is taken on a rising edge where valid_i && ready_o &&
// !flush_i. valid_i seen while ready_o is low is ignored; upstream keeps the
// op stable because stall_o is high for the same cycles. valid_o is a
// single-cycle pulse with no back-pressure from downstream.
// -----------------------------------------------------------------------------
module alu_exec_mc #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic [3:0]      ALUSignal_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            stall_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic [1:0]      dbg_state_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_SLT = 4'd4;
    localparam logic [3:0] OP_MUL = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_SL  = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
    localparam logic [3:0] OP_SRL = 4'd9;

    // Iteration index of the final multiplier bit.
    localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_mplier;
    logic [SHW-1:0]  r_cnt;
    logic            r_valid;
    logic [XLEN-1:0] r_result;
    logic            r_zero;

    logic            w_accept;
    logic            w_is_mul;
    logic [SHW-1:0]  w_shamt;
    logic            w_slt;
    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_acc_next;
    logic            w_mul_last;

    assign ready_o     = (r_state != ST_MUL);
    assign stall_o     = (r_state == ST_MUL);
    assign valid_o     = r_valid;
    assign result_o    = r_result;
    assign zero_o      = r_zero;
    assign dbg_state_o = r_state;

    assign w_accept   = valid_i && ready_o && !flush_i;
    assign w_is_mul   = (ALUSignal_i == OP_MUL);
    assign w_shamt    = src2_i[SHW-1:0];
    assign w_slt      = ($signed(src1_i) < $signed(src2_i));

    // Shift-add step: add the shifted multiplicand when the current
    // multiplier bit is set. Only the low XLEN bits are kept, which is the
    // same for signed and unsigned operands.
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_last = (r_cnt == CNT_LAST);

    always_comb begin
        w_alu = '0;
        case (ALUSignal_i)
            OP_ADD:  w_alu = src1_i + src2_i;
            OP_SUB:  w_alu = src1_i - src2_i;
            OP_AND:  w_alu = src1_i & src2_i;
            OP_OR:   w_alu = src1_i | src2_i;
            OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, w_slt};
            OP_XOR:  w_alu = src1_i ^ src2_i;
            OP_SL:   w_alu = src1_i << w_shamt;
            OP_SRA:  w_alu = $unsigned($signed(src1_i) >>> w_shamt);
            OP_SRL:  w_alu = src1_i >> w_shamt;
            // MUL goes through the iterative engine; codes 10..15 yield 0.
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_MUL: begin
                    if (flush_i) begin
                        // Abandon the product; no valid pulse for it.
                        r_state <= ST_IDLE;
                    end else begin
                        r_acc    <= w_acc_next;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + 1'b1;
                        if (w_mul_last) begin
                            r_state  <= ST_DONE;
                            r_valid  <= 1'b1;
                            r_result <= w_acc_next;
                            r_zero   <= (w_acc_next == '0);
                        end
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new op; DONE lasts one
                    // cycle while the product is presented on valid_o.
                    r_state <= ST_IDLE;
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_state  <= ST_MUL;
                            r_mcand  <= src1_i;
                            r_mplier <= src2_i;
                            r_acc    <= '0;
                            r_cnt    <= '0;
                        end else begin
                            r_valid  <= 1'b1;
                            r_result <= w_alu;
                            r_zero   <= (w_alu == '0);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_mc
//
// Directed bench for alu_exec_mc. A behavioural model (op results via plain
// arithmetic, MUL occupancy as a countdown of remaining stall cycles) tracks
// what every output must be; one compare process checks the DUT against it
// on every falling edge. Directed tasks add hand-computed literal checks of
// results, latencies, stall lengths, flush and reset behaviour.
// -----------------------------------------------------------------------------
module tb_alu_exec_mc;

    localparam int XLEN = 32;

    // ---------------- clock / reset ----------------
    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            valid_i = 1'b0;
    logic [3:0]      ALUSignal_i = 4'd0;
    logic [XLEN-1:0] src1_i = '0;
    logic [XLEN-1:0] src2_i = '0;
    logic            flush_i = 1'b0;
    logic            ready_o;
    logic            stall_o;
    logic            valid_o;
    logic [XLEN-1:0] result_o;
    logic            zero_o;
    logic [1:0]      dbg_state;

    always #5 clk = ~clk;

    alu_exec_mc #(.XLEN(XLEN), .SHW(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_i     (valid_i),
        .ALUSignal_i (ALUSignal_i),
        .src1_i      (src1_i),
        .src2_i      (src2_i),
        .flush_i     (flush_i),
        .ready_o     (ready_o),
        .stall_o     (stall_o),
        .valid_o     (valid_o),
        .result_o    (result_o),
        .zero_o      (zero_o),
        .dbg_state_o (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd5:    return a * b;
            4'd6:    return a ^ b;
            4'd7:    return a << sh;
            4'd8:    return $unsigned($signed(a) >>> sh);
            4'd9:    return a >> sh;
            default: return 32'd0;
        endcase
    endfunction

    int          m_left    = 0;      // stall cycles still owed to a MUL
    logic        m_valid   = 1'b0;
    logic [31:0] m_result  = '0;
    logic        m_zero    = 1'b0;
    logic [31:0] m_pending = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left   = 0;
            m_valid  = 1'b0;
            m_result = '0;
            m_zero   = 1'b0;
        end else if (m_left > 0) begin
            m_valid = 1'b0;
            if (flush_i) begin
                m_left = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_valid  = 1'b1;
                    m_result = m_pending;
                    m_zero   = (m_pending == 0);
                end
            end
        end else begin
            m_valid = 1'b0;
            if (valid_i && !flush_i) begin
                if (ALUSignal_i == 4'd5) begin
                    m_left    = XLEN;
                    m_pending = ref_alu(ALUSignal_i, src1_i, src2_i);
                end else begin
                    m_valid  = 1'b1;
                    m_result = ref_alu(ALUSignal_i, src1_i, src2_i);
                    m_zero   = (m_result == 0);
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp valid_o",  32'(valid_o), 32'(m_valid));
            chk("cmp ready_o",  32'(ready_o), 32'(m_left == 0));
            chk("cmp stall_o",  32'(stall_o), 32'(m_left > 0));
            chk("cmp result_o", result_o,     m_result);
            chk("cmp zero_o",   32'(zero_o),  32'(m_zero));
        end
    end

    // ---------------- pulse recorder / scoreboard ----------------
    int          cyc = 0;
    bit          rec_en = 1'b0;
    logic [31:0] rec_q[$];
    int          rec_c[$];
    logic [31:0] exp_q[$];

    always @(negedge clk) begin
        cyc++;
        if (rec_en && valid_o === 1'b1) begin
            rec_q.push_back(result_o);
            rec_c.push_back(cyc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] lit, input int lat_exp);
        int n;
        int st;
        @(negedge clk);
        valid_i = 1'b1; ALUSignal_i = op; src1_i = a; src2_i = b;
        @(negedge clk);
        valid_i = 1'b0;
        n = 1; st = 0;
        while (valid_o !== 1'b1 && n < 60) begin
            if (stall_o === 1'b1) st++;
            @(negedge clk);
            n++;
        end
        chk({name, " latency"}, 32'(n), 32'(lat_exp));
        chk({name, " stall cycles"}, 32'(st), (lat_exp == XLEN + 1) ? 32'(XLEN) : 32'd0);
        chk({name, " result"}, result_o, lit);
        chk({name, " zero"}, 32'(zero_o), 32'(lit == 0));
    endtask

    task automatic count_valid(input string name, input int cycles);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (valid_o === 1'b1) pulses++;
        end
        chk({name, " stray valid pulses"}, 32'(pulses), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset valid_o",  32'(valid_o), 32'd0);
        chk("reset result_o", result_o,     32'd0);
        chk("reset zero_o",   32'(zero_o),  32'd0);
        chk("reset stall_o",  32'(stall_o), 32'd0);
        chk("reset ready_o",  32'(ready_o), 32'd1);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Single-cycle ops
        run_op("ADD 5+-5",     4'd0, 32'h0000_0005, 32'hFFFF_FFFB, 32'h0000_0000, 1);
        run_op("SUB 3-5",      4'd1, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1);
        run_op("ADD wrap",     4'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1);
        run_op("AND",          4'd2, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1);
        run_op("OR",           4'd3, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1);
        run_op("SLT -1<1",     4'd4, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1);
        run_op("SLT 1<-1",     4'd4, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        run_op("XOR",          4'd6, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 1);
        run_op("SL by 0x24",   4'd7, 32'h0000_0001, 32'h0000_0024, 32'h0000_0010, 1);
        run_op("SRA neg 0x21", 4'd8, 32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 1);
        run_op("SRA pos",      4'd8, 32'h4000_0000, 32'h0000_0004, 32'h0400_0000, 1);
        run_op("SRL 0x21",     4'd9, 32'h8000_0000, 32'h0000_0021, 32'h4000_0000, 1);
        run_op("code 15",      4'd15, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1);

        // Multi-cycle MUL
        run_op("MUL 0x10003x7", 4'd5, 32'h0001_0003, 32'h0000_0007, 32'h0007_0015, 33);
        run_op("MUL -1x-1",     4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
        run_op("MUL 0x5",       4'd5, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 33);

        // Flush blocks accept but the older registered valid_o still shows.
        @(negedge clk);
        valid_i = 1'b1; ALUSignal_i = 4'd0; src1_i = 32'd7; src2_i = 32'd8;
        @(negedge clk);
        chk("flush-old valid_o", 32'(valid_o), 32'd1);
        chk("flush-old result",  result_o,     32'h0000_000F);
        ALUSignal_i = 4'd1; flush_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0; flush_i = 1'b0;
        chk("flushed op valid_o", 32'(valid_o), 32'd0);
        chk("flushed op result held", result_o, 32'h0000_000F);

        // Flush during MUL
        @(negedge clk);
        valid_i = 1'b1; ALUSignal_i = 4'd5; src1_i = 32'h0000_0100; src2_i = 32'd3;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid-MUL stall_o", 32'(stall_o), 32'd1);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        chk("post-flush ready_o", 32'(ready_o), 32'd1);
        chk("post-flush stall_o", 32'(stall_o), 32'd0);
        count_valid("flushed MUL", 40);
        run_op("ADD 1+1 after flush", 4'd0, 32'd1, 32'd1, 32'd2, 1);

        // Asynchronous reset during MUL
        @(negedge clk);
        valid_i = 1'b1; ALUSignal_i = 4'd5; src1_i = 32'h0000_0055; src2_i = 32'd3;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre-reset stall_o", 32'(stall_o), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset valid_o",  32'(valid_o), 32'd0);
        chk("async reset result_o", result_o,     32'd0);
        chk("async reset zero_o",   32'(zero_o),  32'd0);
        chk("async reset stall_o",  32'(stall_o), 32'd0);
        chk("async reset ready_o",  32'(ready_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        count_valid("reset MUL", 40);

        // Streamed ops with valid_i held high
        exp_q = '{32'h0000_0030, 32'h0000_FF00, 32'h0001_2340, 32'h0000_0FF0, 32'h0000_0000};
        rec_q.delete();
        rec_c.delete();
        @(negedge clk);
        rec_en = 1'b1;
        valid_i = 1'b1; ALUSignal_i = 4'd0; src1_i = 32'h10; src2_i = 32'h20;
        @(negedge clk);
        ALUSignal_i = 4'd6; src1_i = 32'hF0F0; src2_i = 32'h0FF0;
        @(negedge clk);
        ALUSignal_i = 4'd5; src1_i = 32'h1234; src2_i = 32'h10;
        @(negedge clk);
        ALUSignal_i = 4'd3; src1_i = 32'h0F00; src2_i = 32'h00F0;
        n = 0;
        while (ready_o !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("stream OR wait bounded", 32'(n < 60), 32'd1);
        @(negedge clk);
        ALUSignal_i = 4'd12; src1_i = 32'h5; src2_i = 32'h6;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (4) @(negedge clk);
        rec_en = 1'b0;
        chk("stream pulse count", 32'(rec_q.size()), 32'(exp_q.size()));
        if (rec_q.size() == exp_q.size()) begin
            for (int i = 0; i < exp_q.size(); i++) begin
                chk($sformatf("stream result %0d", i), rec_q[i], exp_q[i]);
            end
            chk("stream XOR after ADD",  32'(rec_c[1] - rec_c[0]), 32'd1);
            chk("stream MUL after ADD",  32'(rec_c[2] - rec_c[0]), 32'd34);
            chk("stream OR after ADD",   32'(rec_c[3] - rec_c[0]), 32'd35);
            chk("stream c12 after ADD",  32'(rec_c[4] - rec_c[0]), 32'd36);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
